pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush sequencer for the five-stage pipeline. Each cycle it drives the 2-bit write-control of every stage register: 00 load, 01 bubble (clear), 10 hold. It merges memory-wait, load-use, multi-cycle mul/div and branch-redirect requests into one consistent set of controls. It owns the mul/div occupancy counter and the discard flag for a fetch that returns after a redirect.

## Interface
- MUL_LAT, 3, E-stage occupancy in cycles of a multiply (2..63)
- DIV_LAT, 33, E-stage occupancy in cycles of a divide (2..63)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low: state clears while reset==0
- i_wait  in  1  instruction fetch outstanding
- d_wait  in  1  M-stage data access outstanding
- load_use  in  1  D consumes the destination of a load currently in E
- md_start  in  1  E holds a mul/div op; held while that op occupies E
- md_is_div  in  1  qualifies md_start: 1 divide, 0 multiply
- redirect  in  1  E-stage branch mispredict; held stable until accepted
- FWrite, DWrite, EWrite, MWrite, WWrite  out  u2 each  stage write controls (FWrite is the PC: only 00/10)
- redirect_ack  out  1  redirect accepted this cycle
- md_busy  out  1  mul/div is stalling E
- md_done  out  1  mul/div result leaves E this cycle
- stall_cycles  out  32  cycles with FWrite==10 (perf)
- flush_count  out  32  accepted redirects (perf)

## Operation
- State: md_state in {IDLE, BUSY, HOLD}, cnt[5:0], drop_pend, perf counters.
- mdstall = (IDLE && md_start) || BUSY || HOLD, or (BUSY && cnt==0 && d_wait).
- Controls are evaluated in priority order; a later rule never overrides a field already set by an earlier one.
  1. d_wait: F, D, E, M = 10; W = 01.
  2. mdstall: F, D, E = 10; M = 01; W = 00.
  3. redirect (accepted; redirect_ack=1): F=00, D=01, E=01, M=00, W=00. If i_wait also holds, set drop_pend.
  4. load_use: F, D = 10; E = 01; M, W = 00.
  5. i_wait: F=10; D=01; E, M, W = 00.
  6. Otherwise all 00.
- A redirect is accepted only when rules 1–2 are inactive.
- Redirect outranks load_use and i_wait: the instruction in D is wrong-path.
- drop_pend: in the first cycle with i_wait==0 and no rule 1–3 active, force D=01 and clear drop_pend. This discards the stale returned instruction.
- drop_pend holds through stalls. A second redirect while it is set leaves it set.
- Mul/div FSM:
  - IDLE, md_start=1, d_wait=0: cnt <= LAT-2 (LAT selected by md_is_div), go to BUSY.
  - IDLE, md_start=1, d_wait=1: no change (rule 1 already holds E).
  - BUSY, cnt!=0: cnt decrements.
  - BUSY, cnt==0, d_wait=0: release. EWrite follows rules 3–6, md_done=1, go to IDLE.
  - BUSY, cnt==0, d_wait=1: go to HOLD.
  - HOLD: stays until d_wait==0, then releases as above.
- md_start is ignored in BUSY and HOLD.
- md_busy = mdstall, excluding release cycles.
- Perf counters wrap modulo 2^32.

## Timing
- All outputs are combinational from inputs and registered state; there is no added latency.
- A stage register sees its control at the same rising edge.
- Mul/div with no d_wait: E held for exactly LAT cycles, counting the first md_start cycle. md_done is in cycle LAT.
- Reset values: md_state=IDLE, cnt=0, drop_pend=0, counters=0, md_done=0, md_busy=0, redirect_ack=0. Write controls follow inputs combinationally.
- Reset asserted mid-mul/div aborts it immediately. After release, md_start is re-evaluated from IDLE.
- Simultaneous d_wait with any other request: rule 1 only. State advances only as listed above.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles and flush_count are implemented as registered counters.
- PIPE_CTRL_PERF_EN undefined: both ports are tied to 0 and no counter flops are generated.
- Control behaviour is identical either way.

## Test plan
- Mul, MUL_LAT=3, md_start high 3 cycles:
  - EWrite = 10, 10, then 00 with md_done=1.
  - MWrite = 01 in cycles 1–2.
- Div, DIV_LAT=33, d_wait pulses high in cycle 33 for 2 cycles:
  - State goes to HOLD.
  - md_done only in cycle 35.
  - WWrite=01 in cycles 33–34.
- load_use and redirect in the same cycle -> F=00, D=01, E=01, redirect_ack=1.
- redirect while i_wait=1, i_wait drops 2 cycles later:
  - redirect_ack=1, FWrite=00.
  - In the cycle i_wait==0, DWrite=01 and drop_pend clears.
- redirect while md stall active:
  - redirect_ack=0 until the release cycle.
  - flush_count increments by 1 (PERF_EN).
- reset low mid-BUSY -> md_busy=0, state IDLE; with reset high and md_start=1, a fresh LAT count starts.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Stall/flush sequencer bundle: hazard requests from the pipeline toward
// pipe_ctrl, and stage write controls plus mul/div status back from it.
// Write-control encoding: 00 load, 01 bubble (clear), 10 hold.
interface pipe_ctrl_if;
  logic       i_wait;
  logic       d_wait;
  logic       load_use;
  logic       md_start;
  logic       md_is_div;
  logic       redirect;
  logic [1:0] FWrite;
  logic [1:0] DWrite;
  logic [1:0] EWrite;
  logic [1:0] MWrite;
  logic [1:0] WWrite;
  logic       redirect_ack;
  logic       md_busy;
  logic       md_done;

  // Pipeline side: raises requests, consumes controls.
  modport master (
    output i_wait, d_wait, load_use, md_start, md_is_div, redirect,
    input  FWrite, DWrite, EWrite, MWrite, WWrite,
    input  redirect_ack, md_busy, md_done
  );

  // Sequencer side.
  modport slave (
    input  i_wait, d_wait, load_use, md_start, md_is_div, redirect,
    output FWrite, DWrite, EWrite, MWrite, WWrite,
    output redirect_ack, md_busy, md_done
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the five-stage pipeline.
// Merges memory-wait, load-use, mul/div occupancy and branch redirects into
// one set of per-stage write controls (00 load, 01 bubble, 10 hold). Owns the
// mul/div occupancy counter and the flag that discards a fetch returning
// after a redirect.
// Optional feature macro: PIPE_CTRL_PERF_EN -- when defined, stall_cycles and
// flush_count are live 32-bit wrapping counters; otherwise both read 0.
module pipe_ctrl #(
  parameter int unsigned MUL_LAT = 3,   // E occupancy of a multiply, 2..63
  parameter int unsigned DIV_LAT = 33   // E occupancy of a divide, 2..63
) (
  input  logic        clk,
  input  logic        reset,            // asynchronous, active-low
  pipe_ctrl_if.slave  bus,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [1:0] WR_LOAD   = 2'b00;
  localparam logic [1:0] WR_BUBBLE = 2'b01;
  localparam logic [1:0] WR_HOLD   = 2'b10;

  // The first occupancy cycle is the IDLE cycle that sees md_start and the
  // last is the release cycle, so the counter covers LAT-2 cycles in between.
  localparam logic [5:0] MUL_INIT = 6'(MUL_LAT - 2);
  localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 2);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_HOLD = 2'd2
  } md_state_e;

  md_state_e  md_state, md_state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       drop_pend, drop_pend_nxt;

  logic       md_release;
  logic       md_stall;
  logic       accept;
  logic       drop;
  logic [1:0] f_wr, d_wr, e_wr, m_wr, w_wr;

  // Hazard qualification. Everything is gated by reset so that status
  // outputs read idle while the block is held in reset.
  always_comb begin
    md_release = reset && !bus.d_wait &&
                 ((md_state == MD_BUSY && cnt == 6'd0) || md_state == MD_HOLD);
    md_stall   = reset && !md_release &&
                 ((md_state == MD_IDLE && bus.md_start) ||
                  md_state == MD_BUSY || md_state == MD_HOLD);
    // A redirect waits while memory or mul/div is holding E.
    accept     = reset && bus.redirect && !bus.d_wait && !md_stall;
    // The stale fetch is discarded once it has returned and nothing above
    // the redirect rule owns D this cycle.
    drop       = reset && drop_pend && !bus.i_wait && !bus.d_wait &&
                 !md_stall && !accept;
  end

  // Priority-ordered write controls; the first matching rule sets all fields.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    f_wr = WR_LOAD;
    d_wr = WR_LOAD;
    e_wr = WR_LOAD;
    m_wr = WR_LOAD;
    w_wr = WR_LOAD;
    if (bus.d_wait) begin
      f_wr = WR_HOLD;
      d_wr = WR_HOLD;
      e_wr = WR_HOLD;
      m_wr = WR_HOLD;
      w_wr = WR_BUBBLE;
    end else if (md_stall) begin
      f_wr = WR_HOLD;
      d_wr = WR_HOLD;
      e_wr = WR_HOLD;
      m_wr = WR_BUBBLE;
    end else if (accept) begin
      // Wrong-path instructions in D and E are squashed; this outranks
      // load_use because the instruction in D is itself wrong-path.
      d_wr = WR_BUBBLE;
      e_wr = WR_BUBBLE;
    end else if (bus.load_use) begin
      f_wr = WR_HOLD;
      d_wr = WR_HOLD;
      e_wr = WR_BUBBLE;
    end else if (bus.i_wait) begin
      f_wr = WR_HOLD;
      d_wr = WR_BUBBLE;
    end
    if (drop) begin
      d_wr = WR_BUBBLE;
    end
  end

  assign bus.FWrite       = f_wr;
  assign bus.DWrite       = d_wr;
  assign bus.EWrite       = e_wr;
  assign bus.MWrite       = m_wr;
  assign bus.WWrite       = w_wr;
  assign bus.redirect_ack = accept;
  assign bus.md_busy      = md_stall;
  assign bus.md_done      = md_release;

  // Mul/div occupancy FSM and drop flag next-state.
  always_comb begin
    md_state_nxt  = md_state;
    cnt_nxt       = cnt;
    drop_pend_nxt = drop_pend;
    case (md_state)
      MD_IDLE: begin
        // With d_wait high the memory rule already holds E; start later.
        if (bus.md_start && !bus.d_wait) begin
          cnt_nxt      = bus.md_is_div ? DIV_INIT : MUL_INIT;
          md_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt != 6'd0) begin
          cnt_nxt = cnt - 6'd1;
        end else if (bus.d_wait) begin
          md_state_nxt = MD_HOLD;
        end else begin
          md_state_nxt = MD_IDLE;
        end
      end
      MD_HOLD: begin
        if (!bus.d_wait) begin
          md_state_nxt = MD_IDLE;
        end
      end
      default: md_state_nxt = MD_IDLE;
    endcase
    if (accept && bus.i_wait) begin
      drop_pend_nxt = 1'b1;
    end else if (drop) begin
      drop_pend_nxt = 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_state  <= MD_IDLE;
      cnt       <= 6'd0;
      drop_pend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      md_state  <= md_state_nxt;
      cnt       <= cnt_nxt;
      drop_pend <= drop_pend_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Performance counters: PC-hold cycles and accepted redirects, wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (f_wr == WR_HOLD) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (accept) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (MUL_LAT=3, DIV_LAT=33). Inputs change
// 1 time unit after the rising edge; outputs are sampled 3 units after it.
// Control vectors are compared packed as {F,D,E,M,W}.
module tb_pipe_ctrl;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 33;

  localparam logic [9:0] C_ZERO  = 10'b00_00_00_00_00;
  localparam logic [9:0] C_DWAIT = 10'b10_10_10_10_01;
  localparam logic [9:0] C_MD    = 10'b10_10_10_01_00;
  localparam logic [9:0] C_REDIR = 10'b00_01_01_00_00;
  localparam logic [9:0] C_LU    = 10'b10_10_01_00_00;
  localparam logic [9:0] C_IWAIT = 10'b10_01_00_00_00;
  localparam logic [9:0] C_DROP  = 10'b00_01_00_00_00;

  logic        clk;
  logic        reset;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  int          checks;
  int          errors;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [9:0] ctrl();
    return {bus.FWrite, bus.DWrite, bus.EWrite, bus.MWrite, bus.WWrite};
  endfunction

  function automatic logic [1:0] md_st();
    logic [1:0] s;
    s = dut.md_state;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_wait    = 1'b0;
    bus.d_wait    = 1'b0;
    bus.load_use  = 1'b0;
    bus.md_start  = 1'b0;
    bus.md_is_div = 1'b0;
    bus.redirect  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    checks++; if (ctrl() !== C_ZERO) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl(), C_ZERO); end
    checks++; if (md_st() !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", md_st()); end
    checks++; if (dut.drop_pend !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", dut.drop_pend); end
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cycles, flush_count); end
    // Requests during reset must not surface as busy/ack.
    bus.md_start = 1'b1;
    bus.redirect = 1'b1;
    #1;
    checks++; if ({bus.md_busy, bus.md_done, bus.redirect_ack} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {bus.md_busy, bus.md_done, bus.redirect_ack}); end
    tick();
    clear_inputs();
    reset = 1'b1;
    #2;
    checks++; if (ctrl() !== C_ZERO) begin errors++; $display("FAIL idle_ctrl: got %b expected %b", ctrl(), C_ZERO); end
    tick();
  endtask

  task automatic test_mul();
    logic [31:0] s0, exp_s;
    s0 = stall_cycles;
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      if (c < 3) begin
        checks++; if (ctrl() !== C_MD) begin errors++; $display("FAIL mul_ctrl c%0d: got %b expected %b", c, ctrl(), C_MD); end
        checks++; if ({bus.md_busy, bus.md_done} !== 2'b10) begin errors++; $display("FAIL mul_status c%0d: got %b expected 10", c, {bus.md_busy, bus.md_done}); end
      end else begin
        checks++; if (ctrl() !== C_ZERO) begin errors++; $display("FAIL mul_release_ctrl: got %b expected %b", ctrl(), C_ZERO); end
        checks++; if ({bus.md_busy, bus.md_done} !== 2'b01) begin errors++; $display("FAIL mul_release_status: got %b expected 01", {bus.md_busy, bus.md_done}); end
      end
      tick();
    end
    bus.md_start = 1'b0;
    #2;
    checks++; if (md_st() !== 2'd0 || bus.md_done !== 1'b0) begin errors++; $display("FAIL mul_after: state %0d done %b expected 0/0", md_st(), bus.md_done); end
`ifdef PIPE_CTRL_PERF_EN
    exp_s = s0 + 32'd2;
`else
    exp_s = 32'd0;
`endif
    checks++; if (stall_cycles !== exp_s) begin errors++; $display("FAIL mul_stall_cycles: got %0d expected %0d", stall_cycles, exp_s); end
    tick();
  endtask

  task automatic test_div_hold();
    logic [9:0] exp_c;
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b1;
    for (int c = 1; c <= DIV_LAT + 2; c++) begin
      bus.d_wait = (c == DIV_LAT || c == DIV_LAT + 1);
      #2;
      if (c == DIV_LAT || c == DIV_LAT + 1) exp_c = C_DWAIT;
      else if (c == DIV_LAT + 2)            exp_c = C_ZERO;
      else                                  exp_c = C_MD;
      checks++; if (ctrl() !== exp_c) begin errors++; $display("FAIL div_ctrl c%0d: got %b expected %b", c, ctrl(), exp_c); end
      checks++; if (bus.md_done !== (c == DIV_LAT + 2)) begin errors++; $display("FAIL div_done c%0d: got %b expected %b", c, bus.md_done, (c == DIV_LAT + 2)); end
      if (c == DIV_LAT + 1) begin
        checks++; if (md_st() !== 2'd2) begin errors++; $display("FAIL div_hold_state: got %0d expected 2", md_st()); end
      end
      tick();
    end
    clear_inputs();
    #2;
    checks++; if (md_st() !== 2'd0) begin errors++; $display("FAIL div_after_state: got %0d expected 0", md_st()); end
    tick();
  endtask

  task automatic test_redirect_load_use();
    logic [31:0] f0, exp_f;
    f0 = flush_count;
    bus.redirect = 1'b1;
    bus.load_use = 1'b1;
    #2;
    checks++; if (ctrl() !== C_REDIR || bus.redirect_ack !== 1'b1) begin errors++; $display("FAIL redir_lu: got %b ack %b expected %b ack 1", ctrl(), bus.redirect_ack, C_REDIR); end
    tick();
    clear_inputs();
    #2;
    checks++; if (ctrl() !== C_ZERO || dut.drop_pend !== 1'b0) begin errors++; $display("FAIL redir_lu_after: got %b drop %b expected %b drop 0", ctrl(), dut.drop_pend, C_ZERO); end
`ifdef PIPE_CTRL_PERF_EN
    exp_f = f0 + 32'd1;
`else
    exp_f = 32'd0;
`endif
    checks++; if (flush_count !== exp_f) begin errors++; $display("FAIL redir_lu_flush: got %0d expected %0d", flush_count, exp_f); end
    tick();
  endtask

  task automatic test_hazards();
    bus.load_use = 1'b1;
    #2;
    checks++; if (ctrl() !== C_LU) begin errors++; $display("FAIL load_use: got %b expected %b", ctrl(), C_LU); end
    bus.load_use = 1'b0;
    bus.i_wait   = 1'b1;
    #2;
    checks++; if (ctrl() !== C_IWAIT) begin errors++; $display("FAIL i_wait: got %b expected %b", ctrl(), C_IWAIT); end
    // Everything at once: memory wait wins and no state advances.
    bus.d_wait   = 1'b1;
    bus.load_use = 1'b1;
    bus.redirect = 1'b1;
    bus.md_start = 1'b1;
    #1;
    checks++; if (ctrl() !== C_DWAIT || bus.redirect_ack !== 1'b0) begin errors++; $display("FAIL d_wait_prio: got %b ack %b expected %b ack 0", ctrl(), bus.redirect_ack, C_DWAIT); end
    tick();
    #2;
    checks++; if (md_st() !== 2'd0 || dut.drop_pend !== 1'b0) begin errors++; $display("FAIL d_wait_nostate: state %0d drop %b expected 0/0", md_st(), dut.drop_pend); end
    clear_inputs();
    tick();
  endtask

  task automatic test_redirect_iwait();
    logic [9:0] exp_c [4];
    exp_c[0] = C_REDIR;
    exp_c[1] = C_IWAIT;
    exp_c[2] = C_DROP;
    exp_c[3] = C_ZERO;
    for (int c = 0; c < 4; c++) begin
      bus.redirect = (c == 0);
      bus.i_wait   = (c < 2);
      #2;
      checks++; if (ctrl() !== exp_c[c]) begin errors++; $display("FAIL redir_iwait_ctrl c%0d: got %b expected %b", c, ctrl(), exp_c[c]); end
      checks++; if (bus.redirect_ack !== (c == 0)) begin errors++; $display("FAIL redir_iwait_ack c%0d: got %b expected %b", c, bus.redirect_ack, (c == 0)); end
      checks++; if (dut.drop_pend !== (c == 1 || c == 2)) begin errors++; $display("FAIL redir_iwait_drop c%0d: got %b expected %b", c, dut.drop_pend, (c == 1 || c == 2)); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_redirect_md();
    logic [31:0] f0, exp_f;
    f0 = flush_count;
    bus.md_start = 1'b1;
    bus.redirect = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #2;
      if (c < 3) begin
        checks++; if (ctrl() !== C_MD || bus.redirect_ack !== 1'b0) begin errors++; $display("FAIL redir_md_wait c%0d: got %b ack %b expected %b ack 0", c, ctrl(), bus.redirect_ack, C_MD); end
      end else begin
        checks++; if (ctrl() !== C_REDIR || bus.redirect_ack !== 1'b1 || bus.md_done !== 1'b1) begin errors++; $display("FAIL redir_md_release: got %b ack %b done %b expected %b ack 1 done 1", ctrl(), bus.redirect_ack, bus.md_done, C_REDIR); end
      end
      tick();
    end
    clear_inputs();
    #2;
`ifdef PIPE_CTRL_PERF_EN
    exp_f = f0 + 32'd1;
`else
    exp_f = 32'd0;
`endif
    checks++; if (flush_count !== exp_f) begin errors++; $display("FAIL redir_md_flush: got %0d expected %0d", flush_count, exp_f); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bus.md_start  = 1'b1;
    bus.md_is_div = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    checks++; if (md_st() !== 2'd0 || bus.md_busy !== 1'b0 || bus.md_done !== 1'b0) begin errors++; $display("FAIL reset_mid: state %0d busy %b done %b expected 0/0/0", md_st(), bus.md_busy, bus.md_done); end
    tick();
    bus.md_is_div = 1'b0;
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #2;
      checks++; if ({bus.md_busy, bus.md_done} !== ((c < 3) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL reset_restart c%0d: got %b expected %b", c, {bus.md_busy, bus.md_done}, ((c < 3) ? 2'b10 : 2'b01)); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_inputs();
    test_reset();
    test_mul();
    test_div_hold();
    test_redirect_load_use();
    test_hazards();
    test_redirect_iwait();
    test_redirect_md();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
